parallel_to_serial: RTL

Transmit side of the team's serial word link: accepts a WIDTH-bit parallel word through a valid/ready handshake and emits it one bit at a time, MSB first by default. Each bit is presented with its own valid/ready handshake, so the bit stream can be paced by a slow consumer such as the serial_to_parallel receiver driven by key events. A one-cycle frame-start pulse precedes every word and resets the receiver's bit index.

---
 rtl/serial_pkg.sv | 10 +
 rtl/parallel_to_serial.sv | 57 +++++
 2 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM encoding and defaults for the serial word link
package serial_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_t;
endpackage

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: word-in, handshaked bit-out transmitter with a frame-start pulse
module parallel_to_serial
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_start,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_n;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (in_valid && in_ready) begin
                shreg <= in_data;
                cnt   <= '0;
            end else if (ser_valid && ser_ready) begin
                shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
                // the counter parks at the last index; the next load clears it
                cnt   <= ser_last ? cnt : cnt + 1'b1;
            end
        end
    end
    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE) && !rst;
        ser_start = state == START;
        ser_valid = state == SHIFT;
        busy      = state != IDLE;
        ser_last  = (state == SHIFT) && (cnt == LAST);
        ser_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        case (state)
            IDLE:    state_n = in_valid ? START : IDLE;
            START:   state_n = SHIFT;
            SHIFT:   state_n = (ser_ready && ser_last) ? IDLE : SHIFT;
            default: state_n = IDLE;
        endcase
    end
endmodule
